// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product or quotient bit per clock,
// sign handling by magnitude arithmetic with a final correction step.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q, mq_q, mcand_q;
    logic             neg_q, rem_neg_q, b_zero_q;
    logic             busy_q, done_q, zero_q, negative_q, dbz_q;
    logic [WIDTH-1:0] result_q;

    logic             is_div, sign_a, sign_b, rem_ge;
    logic [WIDTH-1:0] mag_a, mag_b, diff, acc_d, mq_d, res_d;
    logic [WIDTH:0]   sum, rem_sh;
    logic [2*WIDTH-1:0] prod;

    // NOTE: every signal of this block is written on every path, so no latch is inferred.
    always_comb begin
        is_div = op_q[2];
        sign_a = a_q[WIDTH-1] & (is_div ? ~op_q[0] : (op_q[1] ^ op_q[0]));
        sign_b = b_q[WIDTH-1] & (is_div ? ~op_q[0] : (op_q[1:0] == 2'b01));
        mag_a  = sign_a ? -a_q : a_q;
        mag_b  = sign_b ? -b_q : b_q;

        // Multiply: LSB-first shift-add into {acc, mq}; divide: restoring on {acc, mq}.
        sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh = {acc_q, mq_q[WIDTH-1]};
        rem_ge = (rem_sh >= {1'b0, mcand_q});
        diff   = rem_sh[WIDTH-1:0] - mcand_q;
        if (is_div) begin
            acc_d = rem_ge ? diff : rem_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], rem_ge};
        end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end

        prod = {acc_q, mq_q};
        if (neg_q) prod = -prod;
        if (!is_div)
            res_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        else if (b_zero_q)
            res_d = op_q[1] ? a_q : '1;
        else if (op_q[1])
            res_d = rem_neg_q ? -acc_q : acc_q;
        else
            res_d = neg_q ? -mq_q : mq_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= B;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    // The first CALC cycle loads magnitudes; the next WIDTH cycles iterate.
                    if (cnt_q == '0) begin
                        acc_q     <= '0;
                        mcand_q   <= is_div ? mag_b : mag_a;
                        mq_q      <= is_div ? mag_a : mag_b;
                        neg_q     <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        b_zero_q  <= (b_q == '0);
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                    end
                    if (cnt_q == CW'(WIDTH)) state_q <= FIX;
                end
                FIX: begin
                    result_q   <= res_d;
                    zero_q     <= (res_d == '0);
                    negative_q <= res_d[WIDTH-1];
                    dbz_q      <= is_div & b_zero_q;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign negative    = negative_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks for muldiv_unit (WIDTH=32) with a result scoreboard
// and exact-latency, abort, ignored-start and back-to-back scenarios.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] A, B;
    logic         busy, done, zero, negative, div_by_zero;
    logic [W-1:0] result;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .negative(negative), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         dbz;
        string        tag;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned e_start = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [W-1:0] res, input logic dbz);
        exp_t e;
        e.res = res;
        e.z   = (res == '0);
        e.n   = res[W-1];
        e.dbz = dbz;
        e.tag = tag;
        return e;
    endfunction

    // Reference built on native 64-bit arithmetic, independent of the iterative datapath.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0]        p;
        logic [W-1:0]          r;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        p  = '0;
        r  = '0;
        case (o)
            3'd0: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
            3'd1: begin p = sa * sb; r = p[2*W-1:W]; end
            3'd2: begin p = sa * $signed({{W{1'b0}}, b}); r = p[2*W-1:W]; end
            3'd3: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
            3'd4: if (b == '0) r = '1; else begin p = sa / sb; r = p[W-1:0]; end
            3'd5: r = (b == '0) ? '1 : a / b;
            3'd6: if (b == '0) r = a; else begin p = sa % sb; r = p[W-1:0]; end
            default: r = (b == '0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Caller is just past a negedge; start is sampled at the next rising edge.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        op = o; A = a; B = b; start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e_start = edge_cnt;
        start = 1'b0;
        op = 3'($urandom);
        A  = $urandom;
        B  = $urandom;
    endtask

    task automatic wait_done();
        exp_t        e;
        bit          seen = 1'b0;
        bit          busy_ok = 1'b1;
        int unsigned delta = 0;
        while (!seen && delta <= 40) begin
            @(negedge clk);
            delta = edge_cnt - e_start;
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        e = sb_q.pop_front();
        check({e.tag, " latency"}, 64'(delta), 64'd34);
        check({e.tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check({e.tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({e.tag, " result"}, 64'(result), 64'(e.res));
        check({e.tag, " zero"}, 64'(zero), 64'(e.z));
        check({e.tag, " negative"}, 64'(negative), 64'(e.n));
        check({e.tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic dbz, input string tag);
        @(negedge clk);
        launch(o, a, b, mk(tag, res, dbz));
        wait_done();
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        bit           done_seen;

        rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst zero", 64'(zero), 64'd1);
        check("rst negative", 64'(negative), 64'd0);
        check("rst div_by_zero", 64'(div_by_zero), 64'd0);

        // MUL with exact timing, then the done pulse must drop while the result holds.
        run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        @(negedge clk);
        check("mul done_pulse_width", 64'(done), 64'd0);
        check("mul busy_after_done", 64'(busy), 64'd0);
        check("mul result_held", 64'(result), 64'hFFFF_FFEB);

        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min");
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1_max");
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        run(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
        run(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
        run(3'b111, 32'd6, 32'd3, 32'd0, 1'b0, "remu_6_3");
        run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_5_0");
        run(3'b110, 32'd5, 32'd0, 32'd5, 1'b1, "rem_5_0");
        run(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_dbz");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem_ovf");

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom);
            ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb = (i % 4 == 1) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            run(ro, ra, rb, model(ro, ra, rb), ro[2] & (rb == '0), $sformatf("rand%0d_op%0d", i, ro));
        end

        // A second start at edge 5 of a DIV must be ignored.
        @(negedge clk);
        launch(3'b100, 32'd100, 32'd7, mk("div_ignore_start", 32'd14, 1'b0));
        repeat (5) @(negedge clk);
        op = 3'b000; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset at edge 10 aborts the operation without a done pulse.
        @(negedge clk);
        launch(3'b101, 32'd1000, 32'd3, mk("aborted", 32'd333, 1'b0));
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort zero", 64'(zero), 64'd1);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        run(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0, "after_abort");

        // start held through DONE: the second op is accepted at the edge leaving DONE.
        @(negedge clk);
        launch(3'b000, 32'd6, 32'd7, mk("b2b_first", 32'd42, 1'b0));
        wait_done();
        launch(3'b101, 32'd1000, 32'd10, mk("b2b_second", 32'd100, 1'b0));
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
